// File: rtl/qpsk_rx_ctrl.sv
// qpsk_rx_ctrl: frame sequencer around a QPSK hard-decision demapper.
// Forwards accepted I/Q samples to the demapper, packs the returned 2-bit
// decisions four per byte (first symbol in [7:6]) and streams the bytes out
// through a small FIFO with valid/ready/last. A done pulse marks frame end.
module qpsk_rx_ctrl #(
  parameter int SAMP_W     = 11,
  parameter int LEN_W      = 12,
  parameter int OBUF_DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [LEN_W-1:0]         frame_len,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic signed [SAMP_W-1:0] ar,
  input  logic signed [SAMP_W-1:0] ai,
  output logic                     dm_valid,
  output logic signed [SAMP_W-1:0] dm_ar,
  output logic signed [SAMP_W-1:0] dm_ai,
  input  logic                     dm_valid_x,
  input  logic [1:0]               dm_x,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [7:0]               byte_data,
  output logic                     byte_last,
  output logic                     busy,
  output logic                     done
);

  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(OBUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] rcv_q, rcv_d;
  logic [7:0]       pack_q, pack_d;
  logic             byte_open_q, byte_open_d;
  logic             zero_done_q, zero_done_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       obuf_q [OBUF_DEPTH];

  logic             accept;
  logic             take_x;
  logic             last_sym;
  logic             push;
  logic             pop;
  logic [LEN_W-1:0] rcv_inc;
  logic [CNT_W:0]   reserved;
  logic [8:0]       head;

  // Input handshake, demapper pass-through and decision bookkeeping.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
    reserved = {1'b0, cnt_q} + {{CNT_W{1'b0}}, byte_open_q};
    // A new byte may only start when a buffer slot is reserved for it.
    ready_o  = (state_q == S_RUN) && (acc_q < len_q) &&
               ((acc_q[1:0] != 2'b00) || (reserved < DEPTH_C));
    accept   = valid_i && ready_o;
    dm_valid = accept;
    dm_ar    = ar;
    dm_ai    = ai;
    take_x   = (state_q == S_RUN) && dm_valid_x && (rcv_q != len_q);
    rcv_inc  = rcv_q + LEN_W'(1);
    last_sym = (rcv_inc == len_q);
    push     = take_x && ((rcv_q[1:0] == 2'b11) || last_sym);
    byte_valid = (cnt_q != '0);
    pop      = byte_valid && byte_ready;
  end

  // Pack register: slot 0 restarts the byte so unused trailing slots read 2'b00.
  always_comb begin
    pack_d = pack_q;
    if (take_x) begin
      case (rcv_q[1:0])
        2'd0:    pack_d = {dm_x, 6'b000000};
        2'd1:    pack_d[5:4] = dm_x;
        2'd2:    pack_d[3:2] = dm_x;
        default: pack_d[1:0] = dm_x;
      endcase
    end
  end

  // Frame FSM next-state and counters.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    rcv_d       = rcv_q;
    byte_open_d = byte_open_q;
    zero_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            state_d     = S_RUN;
            len_d       = frame_len;
            acc_d       = '0;
            rcv_d       = '0;
            byte_open_d = 1'b0;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) acc_d = acc_q + LEN_W'(1);
        if (take_x) rcv_d = rcv_inc;
        // Opening the next byte wins over closing the previous one in the same cycle.
        if (accept && (acc_q[1:0] == 2'b00)) byte_open_d = 1'b1;
        else if (push)                      byte_open_d = 1'b0;
        if (rcv_q == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= S_IDLE;
      len_q       <= '0;
      acc_q       <= '0;
      rcv_q       <= '0;
      pack_q      <= '0;
      byte_open_q <= 1'b0;
      zero_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      rcv_q       <= rcv_d;
      pack_q      <= pack_d;
      byte_open_q <= byte_open_d;
      zero_done_q <= zero_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Byte buffer storage: each entry is {last, data}.
  // NOTE: storage is not reset; the cleared occupancy count marks it empty and the outputs are gated below.
  always_ff @(posedge CLK) begin
    if (push) obuf_q[wr_ptr_q] <= {last_sym, pack_d};
  end

  // Downstream byte port and status outputs.
  always_comb begin
    head      = obuf_q[rd_ptr_q];
    byte_data = byte_valid ? head[7:0] : 8'h00;
    byte_last = byte_valid && head[8];
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE) || zero_done_q;
  end

endmodule

// File: tb/tb_qpsk_rx_ctrl.sv
// tb_qpsk_rx_ctrl: directed bench for qpsk_rx_ctrl with a behavioural
// one-cycle demapper ({ar<0, ai<0}) and a byte monitor feeding golden checks.
module tb_qpsk_rx_ctrl;

  localparam int SAMP_W = 11;
  localparam int LEN_W  = 12;
  localparam logic signed [SAMP_W-1:0] P_MAX = 11'sh3FF;
  localparam logic signed [SAMP_W-1:0] N_MIN = 11'sh400;
  localparam logic signed [SAMP_W-1:0] N_ONE = 11'sh7FF;
  localparam logic signed [SAMP_W-1:0] P300  = 11'sd300;
  localparam logic signed [SAMP_W-1:0] N300  = -11'sd300;

  logic                     clk, rst_n, start;
  logic [LEN_W-1:0]         frame_len;
  logic                     valid_i, ready_o;
  logic signed [SAMP_W-1:0] ar, ai, dm_ar, dm_ai;
  logic                     dm_valid, dm_valid_x;
  logic [1:0]               dm_x;
  logic                     byte_valid, byte_ready;
  logic [7:0]               byte_data;
  logic                     byte_last, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int br_mode  = 0;
  int acc_cnt, done_cnt, last_cnt, ready_seen;
  bit abort, drv_done;
  logic       stall_prev;
  logic [8:0] stall_val;
  logic [8:0] got_q[$];
  logic signed [SAMP_W-1:0] s_ar [64];
  logic signed [SAMP_W-1:0] s_ai [64];

  qpsk_rx_ctrl #(.SAMP_W(SAMP_W), .LEN_W(LEN_W), .OBUF_DEPTH(2)) dut (
    .CLK(clk), .RST(rst_n), .start(start), .frame_len(frame_len),
    .valid_i(valid_i), .ready_o(ready_o), .ar(ar), .ai(ai),
    .dm_valid(dm_valid), .dm_ar(dm_ar), .dm_ai(dm_ai),
    .dm_valid_x(dm_valid_x), .dm_x(dm_x),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_last(byte_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Demapper stand-in: one-cycle latency hard decision on the sign bits.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_valid_x <= 1'b0;
      dm_x       <= 2'b00;
    end else begin
      dm_valid_x <= dm_valid;
      dm_x       <= {dm_ar[SAMP_W-1], dm_ai[SAMP_W-1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Downstream ready pattern: 0 always ready, 1 never ready, 2 random.
  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (br_mode)
        0:       byte_ready = 1'b1;
        1:       byte_ready = 1'b0;
        default: byte_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Mid-cycle monitor: records transfers, counts events, checks hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold", {23'd0, byte_valid, byte_last, byte_data}, {23'd0, 1'b1, stall_val});
      if (byte_valid && byte_ready) begin
        got_q.push_back({byte_last, byte_data});
        if (byte_last) last_cnt++;
      end
      stall_prev = byte_valid && !byte_ready;
      stall_val  = {byte_last, byte_data};
      if (valid_i && ready_o) acc_cnt++;
      if (ready_o) ready_seen++;
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] exp_byte(input int b, input int len);
    logic [7:0] v;
    v = 8'h00;
    for (int s = 0; s < 4; s++) begin
      if (4 * b + s < len)
        v[7-2*s -: 2] = {s_ar[4*b+s][SAMP_W-1], s_ai[4*b+s][SAMP_W-1]};
    end
    return v;
  endfunction

  task automatic begin_frame(input int len);
    got_q.delete();
    acc_cnt = 0; done_cnt = 0; last_cnt = 0; ready_seen = 0;
    start = 1'b1;
    frame_len = LEN_W'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic drive_samples(input int n, input int gap_pct, input int max_cyc);
    int idx = 0;
    int cyc = 0;
    drv_done = 1'b0;
    while (idx < n && cyc < max_cyc && !abort) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        valid_i = 1'b0;
      end else begin
        valid_i = 1'b1;
        ar = s_ar[idx];
        ai = s_ai[idx];
      end
      @(negedge clk);
      if (valid_i && ready_o) idx++;
      tick();
      cyc++;
    end
    valid_i = 1'b0;
    if (!abort) check("drive_timeout", idx, n);
    drv_done = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 300) begin
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, done_cnt > 0, 1);
    repeat (3) tick();
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_bytes(input string tag, input int len);
    int nb;
    nb = (len + 3) / 4;
    check({tag, "_nbytes"}, got_q.size(), nb);
    for (int i = 0; i < nb && i < got_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_q[i][7:0], exp_byte(i, len));
      check($sformatf("%s_last%0d", tag, i), got_q[i][8], (i == nb - 1) ? 1 : 0);
    end
  endtask

  task automatic run_frame(input string tag, input int len, input int gap_pct, input bit poke);
    begin_frame(len);
    check({tag, "_busy"}, busy, 1);
    if (poke) begin
      fork
        begin
          repeat (3) tick();
          start = 1'b1;
          frame_len = LEN_W'(3);
          tick();
          start = 1'b0;
        end
      join_none
    end
    drive_samples(len, gap_pct, 2000);
    wait_done(tag);
    check_bytes(tag, len);
  endtask

  task automatic fill_quad();
    for (int i = 0; i < 64; i++) begin
      s_ar[i] = (i % 4 >= 2) ? N300 : P_MAX;
      s_ai[i] = (i % 2 == 1) ? N_MIN : '0;
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; frame_len = '0; valid_i = 1'b0;
    ar = '0; ai = '0; abort = 1'b0; drv_done = 1'b1;
    acc_cnt = 0; done_cnt = 0; last_cnt = 0; ready_seen = 0;
    stall_prev = 1'b0; stall_val = '0;
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_bvalid", byte_valid, 0);
    check("rst_outs", {byte_last, busy, done, byte_data}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // T1: (+,+)(+,-)(-,+)(-,-) twice -> 0x1B, 0x1B.
    fill_quad();
    run_frame("t1", 8, 0, 1'b0);
    if (got_q.size() >= 2) begin
      check("t1_b0_hand", got_q[0], {1'b0, 8'h1B});
      check("t1_b1_hand", got_q[1], {1'b1, 8'h1B});
    end

    // T2: five (-,-) symbols -> 0xFF then 0xC0 with last.
    for (int i = 0; i < 64; i++) begin
      s_ar[i] = (i % 2 == 0) ? N_ONE : N_MIN;
      s_ai[i] = (i % 2 == 0) ? N_MIN : N_ONE;
    end
    run_frame("t2", 5, 0, 1'b0);
    if (got_q.size() >= 2) begin
      check("t2_b0_hand", got_q[0], {1'b0, 8'hFF});
      check("t2_b1_hand", got_q[1], {1'b1, 8'hC0});
    end

    // T3: blocked downstream stalls input after two buffered bytes.
    for (int i = 0; i < 64; i++) begin
      s_ar[i] = ((i / 3) % 2 == 1) ? N300 : P300;
      s_ai[i] = ((i / 2) % 3 == 0) ? N300 : P300;
    end
    br_mode = 1;
    tick();
    begin_frame(16);
    fork
      drive_samples(16, 0, 400);
    join_none
    repeat (30) tick();
    check("t3_acc8", acc_cnt, 8);
    check("t3_ready_low", ready_o, 0);
    check("t3_bvalid", byte_valid, 1);
    check("t3_no_pop", got_q.size(), 0);
    br_mode = 0;
    cyc = 0;
    while (!drv_done && cyc < 300) begin tick(); cyc++; end
    check("t3_drv_end", drv_done, 1);
    wait_done("t3");
    check_bytes("t3", 16);

    // T4: zero-length frame pulses done once and stays idle.
    begin_frame(0);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    tick();
    check("t4_done_clr", done, 0);
    repeat (10) tick();
    check("t4_done_once", done_cnt, 1);
    check("t4_no_ready", ready_seen, 0);
    check("t4_no_bytes", got_q.size(), 0);

    // T5: start asserted during RUN is ignored.
    fill_quad();
    for (int i = 0; i < 8; i++) s_ai[i] = (i % 3 == 0) ? N300 : P300;
    run_frame("t5", 8, 0, 1'b1);

    // T6: random gaps and random downstream ready, len 37.
    for (int i = 0; i < 64; i++) begin
      s_ar[i] = SAMP_W'($urandom);
      s_ai[i] = SAMP_W'($urandom);
    end
    br_mode = 2;
    run_frame("t6", 37, 30, 1'b0);
    check("t6_last_cnt", last_cnt, 1);
    br_mode = 0;
    tick();

    // T7: reset mid-frame clears everything, then a clean 4-symbol frame.
    begin_frame(40);
    fork
      drive_samples(40, 0, 400);
    join_none
    cyc = 0;
    while (got_q.size() < 3 && cyc < 200) begin tick(); cyc++; end
    check("t7_three", got_q.size() >= 3, 1);
    #2 rst_n = 1'b0;
    abort = 1'b1;
    #1;
    check("t7_rst_ready", ready_o, 0);
    check("t7_rst_bvalid", byte_valid, 0);
    check("t7_rst_outs", {byte_last, busy, done, byte_data}, 0);
    cyc = 0;
    while (!drv_done && cyc < 10) begin tick(); cyc++; end
    check("t7_drv_abort", drv_done, 1);
    abort = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check("t7_no_done", done_cnt, 0);
    check("t7_no_last", last_cnt, 0);
    fill_quad();
    s_ar[1] = N_MIN;
    run_frame("t7b", 4, 0, 1'b0);
    if (got_q.size() >= 1) check("t7b_hand", got_q[0], {1'b1, 8'h3B});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
